// File: rtl/food_placer.sv
// Places food on a random free grid cell using LFSR draws checked against the occupancy map.
// Optional raster-scan fallback after MAX_TRIES draws is enabled by defining FOOD_PLACER_SCAN_EN.
module food_placer #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int X_W       = 5,
    parameter int Y_W       = 5,
    parameter int RAND_W    = 16,
    parameter int MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              place_req,
    input  logic [RAND_W-1:0] rand_in,
    output logic              occ_rd,
    output logic [X_W-1:0]    occ_x,
    output logic [Y_W-1:0]    occ_y,
    input  logic              occ_rd_data,
    output logic [X_W-1:0]    food_x,
    output logic [Y_W-1:0]    food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAW  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;
`ifdef FOOD_PLACER_SCAN_EN
    localparam logic [2:0] S_SCAN_RD  = 3'd6;
    localparam logic [2:0] S_SCAN_CHK = 3'd7;
    localparam logic [2:0] S_EXHAUST  = S_SCAN_RD;
    localparam int         SCAN_W     = $clog2(GRID_W * GRID_H);
    localparam logic [SCAN_W-1:0] LAST_CELL = SCAN_W'(GRID_W * GRID_H - 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(GRID_H - 1);
`else
    localparam logic [2:0] S_EXHAUST  = S_FAIL;
`endif

    localparam int               TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);
    localparam logic [X_W:0]     X_LIM   = (X_W + 1)'(GRID_W);
    localparam logic [Y_W:0]     Y_LIM   = (Y_W + 1)'(GRID_H);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic             rd_next;
    logic [TRY_W-1:0] tries;
    logic [TRY_W-1:0] tries_inc;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic             in_range;
    logic             accept;
`ifdef FOOD_PLACER_SCAN_EN
    logic [SCAN_W-1:0] scan_cnt;
`endif

    // Raw bit-slice mapping; out-of-range draws are simply rejected, never folded.
    assign cx        = rand_in[X_W-1:0];
    assign cy        = rand_in[X_W+Y_W-1:X_W];
    assign in_range  = ({1'b0, cx} < X_LIM) && ({1'b0, cy} < Y_LIM);
    assign tries_inc = tries + TRY_W'(1);
    assign accept    = (state == S_IDLE) && place_req;

    generate
        if (RAND_W > X_W + Y_W) begin : g_unused_rand
            logic unused_rand;
            assign unused_rand = ^rand_in[RAND_W-1:X_W+Y_W];
        end
    endgenerate

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (place_req) state_next = S_DRAW;
            S_DRAW: begin
                if (in_range)                 state_next = S_READ;
                else if (tries_inc == TRY_MAX) state_next = S_EXHAUST;
            end
            S_READ:  state_next = S_CHECK;
            S_CHECK: begin
                if (!occ_rd_data)          state_next = S_DONE;
                else if (tries == TRY_MAX) state_next = S_EXHAUST;
                else                       state_next = S_DRAW;
            end
`ifdef FOOD_PLACER_SCAN_EN
            S_SCAN_RD:  state_next = S_SCAN_CHK;
            S_SCAN_CHK: begin
                if (!occ_rd_data)               state_next = S_DONE;
                else if (scan_cnt == LAST_CELL) state_next = S_FAIL;
                else                            state_next = S_SCAN_RD;
            end
`endif
            S_DONE, S_FAIL: state_next = S_IDLE;
            default:        state_next = S_IDLE;
        endcase

        rd_next = (state_next == S_READ);
`ifdef FOOD_PLACER_SCAN_EN
        rd_next = rd_next || (state_next == S_SCAN_RD);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tries      <= '0;
            occ_rd     <= 1'b0;
            occ_x      <= '0;
            occ_y      <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
`ifdef FOOD_PLACER_SCAN_EN
            scan_cnt   <= '0;
`endif
        end else begin
            state  <= state_next;
            occ_rd <= rd_next;

            // occ_x/occ_y double as the last in-range candidate and the scan cursor.
            if (accept) begin
                tries      <= '0;
                food_valid <= 1'b0;
                occ_x      <= '0;
                occ_y      <= '0;
`ifdef FOOD_PLACER_SCAN_EN
                scan_cnt   <= '0;
`endif
            end

            if (state == S_DRAW) begin
                tries <= tries_inc;
                if (in_range) begin
                    occ_x <= cx;
                    occ_y <= cy;
                end
            end

`ifdef FOOD_PLACER_SCAN_EN
            if ((state == S_SCAN_CHK) && occ_rd_data && (scan_cnt != LAST_CELL)) begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
                if (occ_x == X_LAST) begin
                    occ_x <= '0;
                    occ_y <= (occ_y == Y_LAST) ? '0 : occ_y + Y_W'(1);
                end else begin
                    occ_x <= occ_x + X_W'(1);
                end
            end
`endif

            if (state_next == S_DONE) begin
                food_x     <= occ_x;
                food_y     <= occ_y;
                food_valid <= 1'b1;
            end
        end
    end

    assign busy = (state != S_IDLE) && (state != S_DONE) && (state != S_FAIL);
    assign done = (state == S_DONE);
    assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_food_placer.sv
// Directed self-checking bench for food_placer with a synchronous-read occupancy map model.
// Scan-specific expectations are selected with FOOD_PLACER_SCAN_EN, matching the RTL build.
module tb_food_placer;

    localparam int GRID_W = 32;
    localparam int GRID_H = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        place_req = 1'b0;
    logic [15:0] rand_in = '0;
    logic        occ_rd;
    logic [4:0]  occ_x;
    logic [4:0]  occ_y;
    logic        occ_rd_data = 1'b0;
    logic [4:0]  food_x;
    logic [4:0]  food_y;
    logic        food_valid;
    logic        busy;
    logic        done;
    logic        fail;

    bit occ_map [GRID_H][GRID_W];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int fail_cnt = 0;
    int t0 = 0;
    int rd0 = 0;
    int dn0 = 0;
    int fl0 = 0;

    food_placer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .place_req   (place_req),
        .rand_in     (rand_in),
        .occ_rd      (occ_rd),
        .occ_x       (occ_x),
        .occ_y       (occ_y),
        .occ_rd_data (occ_rd_data),
        .food_x      (food_x),
        .food_y      (food_y),
        .food_valid  (food_valid),
        .busy        (busy),
        .done        (done),
        .fail        (fail)
    );

    always #5 clk = ~clk;

    // Map model answers one cycle after occ_rd; event counters see each completed cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (occ_rd) begin
            rd_cnt      <= rd_cnt + 1;
            occ_rd_data <= (int'(occ_y) < GRID_H) ? occ_map[int'(occ_y)][int'(occ_x)] : 1'b1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (fail) fail_cnt <= fail_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_map(input bit v);
        for (int y = 0; y < GRID_H; y++)
            for (int x = 0; x < GRID_W; x++)
                occ_map[y][x] = v;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Pulse place_req in cycle t0; returns at the negedge of t0+1.
    task automatic start(input logic [15:0] r);
        rand_in   = r;
        place_req = 1'b1;
        t0  = cyc;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        fl0 = fail_cnt;
        @(negedge clk);
        place_req = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", {31'd0, done | fail}, 32'd1);
    endtask

    initial begin
        fill_map(1'b0);

        // Reset held with activity on the inputs.
        place_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rand_in = (i % 2 == 0) ? 16'h0143 : 16'h0064;
        end
        check("reset_outputs",
              {10'd0, occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, done, fail},
              32'd0);
        rst_n     = 1'b1;
        place_req = 1'b0;
        @(negedge clk);
        check("reset_idle_busy", {31'd0, busy}, 32'd0);
        cycles(2);

        // Free first draw, best-case latency.
        start(16'h0143);
        check("free_busy_n1", {30'd0, busy, food_valid}, 32'd2);
        @(negedge clk);
        check("free_rd_n2", {21'd0, occ_rd, occ_x, occ_y}, {21'd0, 1'b1, 5'd3, 5'd10});
        @(negedge clk);
        check("free_rd_off_n3", {30'd0, occ_rd, busy}, 32'd1);
        @(negedge clk);
        check("free_done_n4", {30'd0, done, busy}, 32'd2);
        check("free_food", {22'd0, food_x, food_y}, {22'd0, 5'd3, 5'd10});
        check("free_valid", {31'd0, food_valid}, 32'd1);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        check("req_in_done_ignored", {31'd0, busy}, 32'd0);
        cycles(3);
        check("valid_held", {31'd0, food_valid}, 32'd1);
        check("free_one_read", rd_cnt - rd0, 32'd1);

        // Out-of-range draw (y=30) rejected, then a good draw.
        start(16'h03C5);
        check("oor_valid_cleared", {31'd0, food_valid}, 32'd0);
        @(negedge clk);
        rand_in = 16'h0143;
        wait_end(20);
        check("oor_latency", cyc - t0, 32'd5);
        check("oor_food", {22'd0, food_x, food_y}, {22'd0, 5'd3, 5'd10});
        cycles(2);
        check("oor_one_read", rd_cnt - rd0, 32'd1);

        // Occupied first candidate, free second; busy-time requests ignored.
        occ_map[10][3] = 1'b1;
        start(16'h0143);
        @(negedge clk);
        rand_in   = 16'h0064;
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        cycles(2);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        wait_end(20);
        check("retry_latency", cyc - t0, 32'd7);
        check("retry_food", {22'd0, food_x, food_y}, {22'd0, 5'd4, 5'd3});
        cycles(4);
        check("retry_done_count", done_cnt - dn0, 32'd1);
        check("retry_reads", rd_cnt - rd0, 32'd2);

        // Reset while a read is in flight.
        start(16'h0143);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              {10'd0, occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, done, fail},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);
        check("midrst_quiet", {30'd0, busy, done}, 32'd0);
        check("midrst_no_done", done_cnt - dn0, 32'd0);

        // Every draw lands on an occupied cell; only (4,10) is free.
        fill_map(1'b1);
        occ_map[10][4] = 1'b0;
        start(16'h0143);
        wait_end(400);
`ifdef FOOD_PLACER_SCAN_EN
        check("exh_scan_done", {31'd0, done}, 32'd1);
        check("exh_scan_food", {22'd0, food_x, food_y}, {22'd0, 5'd4, 5'd10});
        check("exh_scan_valid", {31'd0, food_valid}, 32'd1);
        cycles(2);
        check("exh_scan_reads", rd_cnt - rd0, 32'd66);
`else
        check("exh_fail", {31'd0, fail}, 32'd1);
        check("exh_fail_cycle", cyc - t0, 32'd193);
        check("exh_valid", {31'd0, food_valid}, 32'd0);
        cycles(2);
        check("exh_reads", rd_cnt - rd0, 32'd64);
        check("exh_fail_count", fail_cnt - fl0, 32'd1);
        check("exh_busy", {31'd0, busy}, 32'd0);
`endif

`ifdef FOOD_PLACER_SCAN_EN
        // Completely full grid: draws, full scan, then fail.
        fill_map(1'b1);
        start(16'h0143);
        wait_end(2500);
        check("full_fail", {31'd0, fail}, 32'd1);
        cycles(3);
        check("full_reads", rd_cnt - rd0, 32'd832);
        check("full_fail_count", fail_cnt - fl0, 32'd1);
        check("full_idle", {30'd0, busy, food_valid}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/food_placer.md
# food_placer

Consumer side of the game's pseudo-random source: on request, draws random words from the 16-bit LFSR, maps them to grid coordinates and places food on a cell the snake does not occupy. Occupancy comes from the synchronous-read occupancy map. Sits between the game-control FSM (which requests placement) and the renderer/collision logic (which consume `food_x`/`food_y`). A bounded retry count guarantees termination, with a deterministic fallback scan when random draws keep hitting the snake.

## Interface
- `GRID_W`, 32: grid columns; legal x is 0..GRID_W-1.
- `GRID_H`, 24: grid rows; legal y is 0..GRID_H-1.
- `X_W`, 5: x coordinate width; 2^X_W ≥ GRID_W.
- `Y_W`, 5: y coordinate width; 2^Y_W ≥ GRID_H.
- `RAND_W`, 16: random input width; must be ≥ X_W+Y_W.
- `MAX_TRIES`, 64: random draws allowed before fallback or fail.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `place_req` in 1: one-cycle pulse requesting new food placement.
- `rand_in` in RAND_W: LFSR output; new value every cycle.
- `occ_rd` out 1: occupancy read strobe, registered.
- `occ_x` out X_W: occupancy read column, registered.
- `occ_y` out Y_W: occupancy read row, registered.
- `occ_rd_data` in 1: 1 means the cell is occupied; valid in the cycle after `occ_rd`.
- `food_x` out X_W: placed food column.
- `food_y` out Y_W: placed food row.
- `food_valid` out 1: `food_x`/`food_y` hold a placed, free cell.
- `busy` out 1: placement in progress.
- `done` out 1: one-cycle pulse on successful placement.
- `fail` out 1: one-cycle pulse when no free cell was found.

## Operation
**Reset.** All outputs are 0, the FSM is in IDLE, and the try counter is 0.

**Candidate mapping.**
- `cx = rand_in[X_W-1:0]`, `cy = rand_in[X_W+Y_W-1:X_W]`.
- A candidate with `cx ≥ GRID_W` or `cy ≥ GRID_H` is rejected. There is no modulo and no bias correction.

**States and transitions.**
- IDLE:
  - `place_req` → DRAW; `busy`=1, `food_valid`=0, tries=0.
- DRAW:
  - Sample `rand_in`; tries++.
  - In range → READ, latching the candidate into `occ_x`/`occ_y`.
  - Out of range → DRAW again, or EXHAUST if tries == MAX_TRIES.
- READ:
  - `occ_rd`=1 → CHECK.
- CHECK:
  - `occ_rd_data`=0 → latch `food_x`/`food_y` = candidate → DONE.
  - `occ_rd_data`=1 → DRAW, or EXHAUST if tries == MAX_TRIES.
- EXHAUST: behaviour depends on configuration (see Configuration).
- DONE:
  - `done`=1, `food_valid`=1, `busy`=0 → IDLE.
- FAIL:
  - `fail`=1, `food_valid`=0, `busy`=0 → IDLE.

**Boundary rules.**
- `place_req` while `busy`=1 is ignored. It is not queued.
- `place_req` in the DONE or FAIL cycle is ignored.
- Reset mid-operation aborts to IDLE with all outputs 0. Any in-flight `occ_rd_data` is discarded.
- `food_valid` stays high from DONE until the next accepted `place_req`.

## Timing
- Best case: `place_req` high in cycle N → DRAW N+1, READ N+2, CHECK N+3, `done` high in N+4.
- Each out-of-range draw adds 1 cycle.
- Each occupied in-range draw adds 3 cycles.
- Scan costs 2 cycles per cell (SCAN_RD, then SCAN_CHK).
- `busy` is high from N+1 through the cycle before DONE/FAIL.
- `occ_rd` is high for exactly one cycle per read.

## Configuration
Macro: `FOOD_PLACER_SCAN_EN`.

**Defined:** EXHAUST enters a raster scan.
- Start cell: the last in-range candidate, or (0,0) if none was drawn.
- SCAN_RD: read the cell.
- SCAN_CHK:
  - Free cell → latch food → DONE.
  - Occupied → advance x; at x = GRID_W-1, set x=0 and y++; at y = GRID_H-1, wrap y to 0.
- After GRID_W·GRID_H cells with no free cell → FAIL.

**Undefined:** EXHAUST → FAIL immediately, one cycle after the last draw.

## Test plan
- Reset test: hold `rst_n`=0 with `place_req`=1 and `rand_in` toggling → all outputs 0. Release → `busy`=0.
- Free first draw: `rand_in`=16'h0143, empty map, pulse `place_req` at N → `occ_rd` at N+2 with (3,10), `done` at N+4, `food_x`=3, `food_y`=10, `food_valid`=1.
- Out-of-range reject: `rand_in`=16'h03C5 (y=30) at N+1, then 16'h0143 → `done` at N+5 with (3,10). Exactly one `occ_rd` is issued.
- Occupied retry: cell (3,10) occupied, second draw 16'h0064 (4,3) free → `done` at N+7, food=(4,3). `place_req` pulses during `busy` produce no extra `done`.
- Exhaustion: `rand_in` fixed at 16'h0143, only (4,10) free.
  - With `FOOD_PLACER_SCAN_EN`: 64 draws, then `done` with food=(4,10).
  - Without it: `fail` one cycle after the 64th CHECK; `food_valid`=0.
- Full grid with `FOOD_PLACER_SCAN_EN`: all 768 cells occupied → exactly 768 scan reads, then one `fail` pulse; `busy` drops and `food_valid`=0.
